// File: rtl/bidir_bus_xcvr.sv
// Registered bidirectional transceiver between tri-state buses A and B.
// Direction reversals pass through a TURN window with both sides released.

module bidir_bus_xcvr_lane (
    input  logic clk,
    input  logic rst,
    input  logic cap_a,
    input  logic cap_b,
    input  logic a_bit,
    input  logic b_bit,
    output logic q
);
    always_ff @(posedge clk) begin
        if (rst)        q <= 1'b0;
        else if (cap_a) q <= a_bit;
        else if (cap_b) q <= b_bit;
    end
endmodule

module bidir_bus_xcvr #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] A,
    inout  wire  [WIDTH-1:0] B,
    input  logic             en,
    input  logic             dir_req,
    output logic             a_oe,
    output logic             b_oe,
    output logic             dir_cur,
    output logic             busy
);
    localparam int CW = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DRV_AB, DRV_BA, TURN} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           target, target_n;
    logic           dir_cur_n;
    logic           cap_a, cap_b;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            target  <= 1'b0;
            dir_cur <= 1'b0;
            a_oe    <= 1'b0;
            b_oe    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            target  <= target_n;
            dir_cur <= dir_cur_n;
            // oe flags are decoded from the next state so they land with it
            a_oe    <= (state_n == DRV_BA);
            b_oe    <= (state_n == DRV_AB);
            busy    <= (state_n == TURN);
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        target_n  = target;
        dir_cur_n = dir_cur;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n   = dir_req ? DRV_AB : DRV_BA;
                    dir_cur_n = dir_req;
                end
            end
            DRV_AB: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (!dir_req) begin
                    state_n  = TURN;
                    target_n = 1'b0;
                    cnt_n    = CW'(TURN_CYCLES);
                end
            end
            DRV_BA: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (dir_req) begin
                    state_n  = TURN;
                    target_n = 1'b1;
                    cnt_n    = CW'(TURN_CYCLES);
                end
            end
            TURN: begin
                // target is frozen here; dir_req is re-examined once driving
                if (!en) begin
                    state_n = IDLE;
                end else if (cnt == CW'(1)) begin
                    state_n   = target ? DRV_AB : DRV_BA;
                    dir_cur_n = target;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture on the edge that enters or stays in a drive state, so the
    // first driven value is the freshly sampled source.
    assign cap_a = (state_n == DRV_AB);
    assign cap_b = (state_n == DRV_BA);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        bidir_bus_xcvr_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .cap_a (cap_a),
            .cap_b (cap_b),
            .a_bit (A[i]),
            .b_bit (B[i]),
            .q     (data_q[i])
        );
    end

    assign A = a_oe ? data_q : {WIDTH{1'bz}};
    assign B = b_oe ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_bus_xcvr.sv
// Directed bench for bidir_bus_xcvr: an 8-bit/2-cycle-turn instance and a
// 16-bit/1-cycle-turn instance, each checked against hand-computed values.

module tb_bidir_bus_xcvr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // 8-bit instance
    logic       rst8 = 1'b1, en8 = 1'b0, dir8 = 1'b0;
    logic       a8_en = 1'b0, b8_en = 1'b0;
    logic [7:0] a8_val = '0, b8_val = '0;
    wire  [7:0] A8, B8;
    logic       a_oe8, b_oe8, dir_cur8, busy8;
    assign A8 = a8_en ? a8_val : 8'hzz;
    assign B8 = b8_en ? b8_val : 8'hzz;

    bidir_bus_xcvr #(.WIDTH(8), .TURN_CYCLES(2)) dut8 (
        .clk(clk), .rst(rst8), .A(A8), .B(B8), .en(en8), .dir_req(dir8),
        .a_oe(a_oe8), .b_oe(b_oe8), .dir_cur(dir_cur8), .busy(busy8)
    );

    // 16-bit instance
    logic        rst16 = 1'b1, en16 = 1'b0, dir16 = 1'b0;
    logic        a16_en = 1'b0, b16_en = 1'b0;
    logic [15:0] a16_val = '0, b16_val = '0;
    wire  [15:0] A16, B16;
    logic        a_oe16, b_oe16, dir_cur16, busy16;
    assign A16 = a16_en ? a16_val : 16'hzzzz;
    assign B16 = b16_en ? b16_val : 16'hzzzz;

    bidir_bus_xcvr #(.WIDTH(16), .TURN_CYCLES(1)) dut16 (
        .clk(clk), .rst(rst16), .A(A16), .B(B16), .en(en16), .dir_req(dir16),
        .a_oe(a_oe16), .b_oe(b_oe16), .dir_cur(dir_cur16), .busy(busy16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one edge, sample 1ns later, and check oe exclusivity every cycle
    task automatic tick();
        @(posedge clk);
        #1;
        chk("oe_excl8", 32'(a_oe8 & b_oe8), 32'd0);
        chk("oe_excl16", 32'(a_oe16 & b_oe16), 32'd0);
    endtask

    task automatic st8(input string tag, input logic a, input logic b, input logic bz, input logic d);
        chk({tag, ".a_oe"}, 32'(a_oe8), 32'(a));
        chk({tag, ".b_oe"}, 32'(b_oe8), 32'(b));
        chk({tag, ".busy"}, 32'(busy8), 32'(bz));
        chk({tag, ".dir_cur"}, 32'(dir_cur8), 32'(d));
    endtask

    task automatic st16(input string tag, input logic a, input logic b, input logic bz, input logic d);
        chk({tag, ".a_oe"}, 32'(a_oe16), 32'(a));
        chk({tag, ".b_oe"}, 32'(b_oe16), 32'(b));
        chk({tag, ".busy"}, 32'(busy16), 32'(bz));
        chk({tag, ".dir_cur"}, 32'(dir_cur16), 32'(d));
    endtask

    initial begin
        // reset dominates en/dir_req
        rst8 = 1'b1; en8 = 1'b1; dir8 = 1'b1;
        a8_en = 1'b1; a8_val = 8'h11;
        tick(); tick();
        st8("rst", 0, 0, 0, 0);

        // IDLE -> DRV_AB, 1-clock latency
        rst8 = 1'b0; a8_val = 8'h5A;
        tick();
        st8("ab_entry", 0, 1, 0, 1);
        chk("ab_B_5A", 32'(B8), 32'h5A);
        a8_val = 8'hC3;
        tick();
        chk("ab_B_C3", 32'(B8), 32'hC3);

        // AB -> BA through a 2-cycle turnaround
        dir8 = 1'b0; a8_en = 1'b0;
        tick();
        st8("turn1", 0, 0, 1, 1);
        b8_en = 1'b1; b8_val = 8'h3C;
        tick();
        st8("turn2", 0, 0, 1, 1);
        tick();
        st8("ba_entry", 1, 0, 0, 0);
        chk("ba_A_3C", 32'(A8), 32'h3C);
        b8_val = 8'h77;
        tick();
        chk("ba_A_77", 32'(A8), 32'h77);

        // en drop releases at once; re-enable with same direction skips TURN
        en8 = 1'b0;
        tick();
        st8("idle_drop", 0, 0, 0, 0);
        en8 = 1'b1; b8_val = 8'h96;
        tick();
        st8("ba_reent", 1, 0, 0, 0);
        chk("ba_A_96", 32'(A8), 32'h96);

        // dir_req toggled during TURN is ignored; mismatch then restarts TURN
        dir8 = 1'b1;
        tick();
        st8("t2_1", 0, 0, 1, 0);
        b8_en = 1'b0; a8_en = 1'b1; a8_val = 8'hA5; dir8 = 1'b0;
        tick();
        st8("t2_2", 0, 0, 1, 0);
        tick();
        st8("ab_after_toggle", 0, 1, 0, 1);
        chk("ab_B_A5", 32'(B8), 32'hA5);
        tick();
        st8("t3_1", 0, 0, 1, 1);
        tick();
        st8("t3_2", 0, 0, 1, 1);
        en8 = 1'b0;
        tick();
        st8("turn_drop", 0, 0, 0, 1);
        tick();
        st8("idle_hold", 0, 0, 0, 1);

        // 16-bit, single-cycle turnaround
        en16 = 1'b1; dir16 = 1'b1;
        tick(); tick();
        st16("rst16", 0, 0, 0, 0);
        rst16 = 1'b0; a16_en = 1'b1; a16_val = 16'h1234;
        tick();
        st16("w_ab", 0, 1, 0, 1);
        chk("w_B_1234", 32'(B16), 32'h1234);
        dir16 = 1'b0; a16_en = 1'b0;
        tick();
        st16("w_turn", 0, 0, 1, 1);
        b16_en = 1'b1; b16_val = 16'hBEEF;
        tick();
        st16("w_ba", 1, 0, 0, 0);
        chk("w_A_BEEF", 32'(A16), 32'hBEEF);
        dir16 = 1'b1;
        tick();
        st16("w_turn2", 0, 0, 1, 0);
        dir16 = 1'b0; b16_en = 1'b0; a16_en = 1'b1; a16_val = 16'hBEEF;
        tick();
        st16("w_ab2", 0, 1, 0, 1);
        chk("w_B_BEEF", 32'(B16), 32'hBEEF);

        // reset mid-drive releases at that edge; fresh data afterwards
        dir16 = 1'b1; rst16 = 1'b1;
        tick();
        st16("w_rst_mid", 0, 0, 0, 0);
        rst16 = 1'b0; a16_val = 16'hCAFE;
        tick();
        st16("w_post_rst", 0, 1, 0, 1);
        chk("w_B_CAFE", 32'(B16), 32'hCAFE);
        dir16 = 1'b0; a16_en = 1'b0;
        tick();
        st16("w_turn3", 0, 0, 1, 1);
        en16 = 1'b0;
        tick();
        st16("w_turn_drop", 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
